// File: rtl/mem_access_seq_if.sv
// Control-unit side bundle for the shared memory sequencer: requests, jump, memory handshake
// and the sequencer's registered outputs.
interface mem_access_seq_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  i_fetch_en;
  logic                  i_data_req;
  logic                  i_data_we;
  logic                  i_data_ir;
  logic [31:0]           i_data_addr;
  logic                  i_pop_req;
  logic [31:0]           i_pop_addr;
  logic                  i_jump;
  logic [31:0]           i_jump_target;
  logic                  i_mem_ready;
  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [1:0]            o_mode;
  logic [31:0]           o_pc;
  logic                  o_instr_valid;
  logic                  o_data_done;
  logic                  o_pop_done;
  logic                  o_busy;

  modport master (
    output i_fetch_en, i_data_req, i_data_we, i_data_ir, i_data_addr, i_pop_req, i_pop_addr,
           i_jump, i_jump_target, i_mem_ready,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mode, o_pc, o_instr_valid, o_data_done,
           o_pop_done, o_busy
  );

  modport slave (
    input  i_fetch_en, i_data_req, i_data_we, i_data_ir, i_data_addr, i_pop_req, i_pop_addr,
           i_jump, i_jump_target, i_mem_ready,
    output o_mem_req, o_mem_we, o_mem_addr, o_mode, o_pc, o_instr_valid, o_data_done,
           o_pop_done, o_busy
  );
endinterface

// File: rtl/mem_access_seq.sv
// Shared memory port sequencer: owns the PC and arbitrates data > pop > fetch onto one
// request/ready port. Every output comes straight from a register.
module mem_access_seq #(
  parameter int          MEM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic           clk,
  input logic           rst,
  mem_access_seq_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, POP} state_e;

  localparam logic [1:0] M_FETCH = 2'b00, M_IR = 2'b01, M_POP = 2'b10, M_DATA = 2'b11;

  state_e                state_q, state_d;
  logic                  req_q, req_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            mode_q, mode_d;
  logic [31:0]           pc_q, pc_d;
  logic                  ivld_q, ivld_d, ddone_q, ddone_d, pdone_q, pdone_d, busy_q;
  logic                  jmp_q, jmp_d;   // a jump landed while the current fetch was outstanding

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    pc_d    = pc_q;
    ivld_d  = 1'b0;
    ddone_d = 1'b0;
    pdone_d = 1'b0;
    jmp_d   = 1'b0;
    if (bus.i_jump) pc_d = bus.i_jump_target;
    unique case (state_q)
      IDLE: begin
        if (bus.i_data_req) begin
          state_d = DATA;
          req_d   = 1'b1;
          we_d    = bus.i_data_we;
          addr_d  = bus.i_data_addr[ADDR_WIDTH-1:0];
          mode_d  = bus.i_data_ir ? M_IR : M_DATA;
        end else if (bus.i_pop_req) begin
          state_d = POP;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = bus.i_pop_addr[ADDR_WIDTH-1:0];
          mode_d  = M_POP;
        end else if (bus.i_fetch_en && !bus.i_jump) begin
          // a jump this cycle holds off the fetch so it issues from the new PC
          state_d = FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = {pc_q[ADDR_WIDTH-1:1], 1'b0};
          mode_d  = M_FETCH;
        end
      end
      FETCH: begin
        jmp_d = jmp_q | bus.i_jump;
        if (bus.i_mem_ready) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          jmp_d   = 1'b0;
          if (!(jmp_q || bus.i_jump)) begin
            ivld_d = 1'b1;
            pc_d   = pc_q + 32'd2;
          end
        end
      end
      DATA, POP: begin
        if (bus.i_mem_ready) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ddone_d = (state_q == DATA);
          pdone_d = (state_q == POP);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      mode_q  <= M_FETCH;
      pc_q    <= RESET_PC;
      ivld_q  <= 1'b0;
      ddone_q <= 1'b0;
      pdone_q <= 1'b0;
      busy_q  <= 1'b0;
      jmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      pc_q    <= pc_d;
      ivld_q  <= ivld_d;
      ddone_q <= ddone_d;
      pdone_q <= pdone_d;
      busy_q  <= (state_d != IDLE);
      jmp_q   <= jmp_d;
    end
  end

  assign bus.o_mem_req     = req_q;
  assign bus.o_mem_we      = we_q;
  assign bus.o_mem_addr    = addr_q;
  assign bus.o_mode        = mode_q;
  assign bus.o_pc          = pc_q;
  assign bus.o_instr_valid = ivld_q;
  assign bus.o_data_done   = ddone_q;
  assign bus.o_pop_done    = pdone_q;
  assign bus.o_busy        = busy_q;
endmodule
